st_commit_queue: RTL and testbench

Two-stage store queue that sits directly downstream of the store unit. It accepts translated stores (physical address, aligned data, byte enables) one cycle after address translation and holds them speculatively until the commit stage retires them. Retired stores move into a non-speculative commit FIFO that drains to the data cache request port. It also reports to the load unit whether a pending store may alias a load's page offset.

---
 rtl/st_commit_queue_pkg.sv | 25 ++
 rtl/st_fifo.sv | 84 ++++++++
 rtl/st_commit_queue.sv | 150 +++++++++++++++
 tb/tb_st_commit_queue.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_commit_queue_pkg.sv
// Shared types for the store commit queue: the queued store entry and the
// page-offset slice compared against load addresses.
package st_commit_queue_pkg;

  localparam int unsigned ST_PLEN = 56;
  localparam int unsigned ST_XLEN = 64;
  localparam int unsigned ST_BE_W = ST_XLEN / 8;

  // Loads and stores may alias if they touch the same dword within a page.
  localparam int unsigned PO_HI = 11;
  localparam int unsigned PO_LO = 3;
  localparam int unsigned PO_W  = PO_HI - PO_LO + 1;

  typedef struct packed {
    logic [ST_PLEN-1:0] paddr;
    logic [ST_XLEN-1:0] data;
    logic [ST_BE_W-1:0] be;
    logic [1:0]         size;
  } st_entry_t;

  function automatic logic [PO_W-1:0] page_offset_slice(input logic [ST_PLEN-1:0] paddr);
    return paddr[PO_HI:PO_LO];
  endfunction

endpackage

// File: rtl/st_fifo.sv
// Circular FIFO of store entries. Exposes the head entry combinationally and,
// for the alias comparator, a per-slot valid bit plus each slot's page-offset
// slice. A flush clears pointers and count; a pop in the flush cycle still
// sees the head entry, so the caller can capture it before the clear.
module st_fifo
  import st_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  st_entry_t                 push_entry_i,
  input  logic                      pop_i,
  output st_entry_t                 head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    cnt_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [DEPTH*PO_W-1:0]     offset_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  st_entry_t mem_reg [DEPTH];

  // Next-state for pointers and count; flush wins over push/pop bookkeeping.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      cnt_next    = '0;
    end else begin
      if (push_i) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop_i)  rd_ptr_next = rd_ptr_reg + PW'(1);
      cnt_next = cnt_reg + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_reg[wr_ptr_reg] <= push_entry_i;
  end

  assign head_o  = mem_reg[rd_ptr_reg];
  assign full_o  = (cnt_reg == FULL_CNT);
  assign empty_o = (cnt_reg == '0);
  assign cnt_o   = cnt_reg;

  // A slot is live when its distance from the read pointer is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < int'(DEPTH); gi++) begin : g_slot
      logic [PW-1:0] age;
      assign age          = PW'(gi) - rd_ptr_reg;
      assign valid_o[gi]  = ({1'b0, age} < cnt_reg);
      assign offset_o[gi*PO_W +: PO_W] = page_offset_slice(mem_reg[gi].paddr);
    end
  endgenerate

endmodule

// File: rtl/st_commit_queue.sv
// Two-stage store queue: a speculative FIFO holding translated stores until
// the commit stage retires them, feeding a non-speculative commit FIFO that
// drains to the dcache write port. Also flags possible load/store aliasing.
// Build option ST_COMMIT_QUEUE_PAGE_CHECK_EN: when defined, a real page-offset
// comparator is built; otherwise loads are stalled whenever any store is
// pending or arriving.
module st_commit_queue
  import st_commit_queue_pkg::*;
#(
  parameter int unsigned PLEN         = ST_PLEN,
  parameter int unsigned XLEN         = ST_XLEN,
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        size_i,
  input  logic              commit_i,
  output logic              commit_ready_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o,
  output logic              empty_o,
  output logic              no_st_pending_o,
  output logic              req_o,
  output logic [PLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [1:0]        size_o,
  input  logic              gnt_i
);

  localparam int unsigned SCW = $clog2(SPEC_DEPTH) + 1;
  localparam int unsigned CCW = $clog2(COMMIT_DEPTH) + 1;

  st_entry_t in_entry;
  st_entry_t spec_head;
  st_entry_t commit_head;

  logic spec_push, commit_fire, grant_fire;
  logic spec_full, spec_empty, commit_full, commit_empty;

  logic [SCW-1:0]               spec_cnt;
  logic [CCW-1:0]               commit_cnt;
  logic [SPEC_DEPTH-1:0]        spec_valid;
  logic [COMMIT_DEPTH-1:0]      commit_valid;
  logic [SPEC_DEPTH*PO_W-1:0]   spec_offsets;
  logic [COMMIT_DEPTH*PO_W-1:0] commit_offsets;

  assign in_entry = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};

  // Ready and commit-ready come from registered state only: a commit or a
  // grant in the same cycle never frees a slot for a concurrent push/commit.
  assign ready_o        = !spec_full;
  assign commit_ready_o = !commit_full && !spec_empty;

  assign spec_push   = valid_i && ready_o && !flush_i;
  assign commit_fire = commit_i && commit_ready_o;
  assign grant_fire  = req_o && gnt_i;

  // Speculative stage: flush drops everything, but a same-cycle commit still
  // pops the head, which the commit FIFO captures on that edge.
  st_fifo #(
    .DEPTH (SPEC_DEPTH)
  ) u_spec_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (spec_push),
    .push_entry_i (in_entry),
    .pop_i        (commit_fire),
    .head_o       (spec_head),
    .full_o       (spec_full),
    .empty_o      (spec_empty),
    .cnt_o        (spec_cnt),
    .valid_o      (spec_valid),
    .offset_o     (spec_offsets)
  );

  // Committed stage: architecturally visible stores, only lost on reset.
  st_fifo #(
    .DEPTH (COMMIT_DEPTH)
  ) u_commit_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (1'b0),
    .push_i       (commit_fire),
    .push_entry_i (spec_head),
    .pop_i        (grant_fire),
    .head_o       (commit_head),
    .full_o       (commit_full),
    .empty_o      (commit_empty),
    .cnt_o        (commit_cnt),
    .valid_o      (commit_valid),
    .offset_o     (commit_offsets)
  );

  // The request is the commit FIFO head; it only changes on a grant, so the
  // fields are stable while waiting.
  assign req_o   = !commit_empty;
  assign addr_o  = commit_head.paddr;
  assign wdata_o = commit_head.data;
  assign be_o    = commit_head.be;
  assign size_o  = commit_head.size;

  assign empty_o         = spec_empty && commit_empty;
  assign no_st_pending_o = commit_empty;

`ifdef ST_COMMIT_QUEUE_PAGE_CHECK_EN
  logic [PO_W-1:0]         load_offset;
  logic [SPEC_DEPTH-1:0]   spec_hit;
  logic [COMMIT_DEPTH-1:0] commit_hit;
  logic                    incoming_hit;
  logic                    unused_bits;

  assign load_offset = page_offset_i[PO_HI:PO_LO];

  genvar gi;
  generate
    for (gi = 0; gi < int'(SPEC_DEPTH); gi++) begin : g_spec_cmp
      assign spec_hit[gi] = spec_valid[gi] &&
                            (spec_offsets[gi*PO_W +: PO_W] == load_offset);
    end
    for (gi = 0; gi < int'(COMMIT_DEPTH); gi++) begin : g_commit_cmp
      assign commit_hit[gi] = commit_valid[gi] &&
                              (commit_offsets[gi*PO_W +: PO_W] == load_offset);
    end
  endgenerate

  assign incoming_hit = valid_i && (page_offset_slice(paddr_i) == load_offset);

  assign page_offset_matches_o = (|spec_hit) || (|commit_hit) || incoming_hit;

  assign unused_bits = ^{page_offset_i[PO_LO-1:0], spec_cnt, commit_cnt};
`else
  logic unused_bits;

  // No comparator: any pending or arriving store may alias.
  assign page_offset_matches_o = !empty_o || valid_i;

  assign unused_bits = ^{page_offset_i, spec_valid, commit_valid,
                         spec_offsets, commit_offsets, spec_cnt, commit_cnt};
`endif

endmodule

// File: tb/tb_st_commit_queue.sv
// Directed bench for st_commit_queue: fill, commit/drain, flush with commit,
// simultaneous push/commit/grant, full commit FIFO, page-offset check and
// asynchronous reset mid-drain.
module tb_st_commit_queue;

  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int BW   = XLEN / 8;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [PLEN-1:0] paddr_i = '0;
  logic [XLEN-1:0] data_i = '0;
  logic [BW-1:0]   be_i = '0;
  logic [1:0]      size_i = '0;
  logic            commit_i = 1'b0;
  logic            commit_ready_o;
  logic [11:0]     page_offset_i = '0;
  logic            page_offset_matches_o;
  logic            empty_o;
  logic            no_st_pending_o;
  logic            req_o;
  logic [PLEN-1:0] addr_o;
  logic [XLEN-1:0] wdata_o;
  logic [BW-1:0]   be_o;
  logic [1:0]      size_o;
  logic            gnt_i = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  st_commit_queue #(
    .PLEN(PLEN), .XLEN(XLEN), .SPEC_DEPTH(4), .COMMIT_DEPTH(4)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .paddr_i               (paddr_i),
    .data_i                (data_i),
    .be_i                  (be_i),
    .size_i                (size_i),
    .commit_i              (commit_i),
    .commit_ready_o        (commit_ready_o),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o),
    .empty_o               (empty_o),
    .no_st_pending_o       (no_st_pending_o),
    .req_o                 (req_o),
    .addr_o                (addr_o),
    .wdata_o               (wdata_o),
    .be_o                  (be_o),
    .size_o                (size_o),
    .gnt_i                 (gnt_i)
  );

  always #5 clk_i = ~clk_i;

  // Per-address data pattern so payload mix-ups show up.
  function automatic logic [XLEN-1:0] data_of(input logic [PLEN-1:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction
  function automatic logic [BW-1:0] be_of(input logic [PLEN-1:0] a);
    return a[10:3] ^ 8'h5A;
  endfunction
  function automatic logic [1:0] size_of(input logic [PLEN-1:0] a);
    return a[4:3];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_store(input logic [PLEN-1:0] a);
    valid_i = 1'b1;
    paddr_i = a;
    data_i  = data_of(a);
    be_i    = be_of(a);
    size_i  = size_of(a);
  endtask

  // One line per accepted transaction, plus protocol check on commit_i.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (valid_i && ready_o && !flush_i) $display("push   addr=%h", paddr_i);
      if (commit_i && commit_ready_o)     $display("commit");
      if (req_o && gnt_i)                 $display("grant  addr=%h", addr_o);
      if (flush_i)                        $display("flush");
      if (commit_i && !commit_ready_o) begin
        n_checks++;
        n_fails++;
        $display("FAIL commit_protocol: commit_i=1 while commit_ready_o=%b, required 1", commit_ready_o);
      end
    end
  end

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL reset_commit_ready: got %b expected 0", commit_ready_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b expected 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    n_checks++; if (no_st_pending_o !== 1'b1) begin n_fails++; $display("FAIL reset_no_st_pending: got %b expected 1", no_st_pending_o); end
    n_checks++; if (page_offset_matches_o !== 1'b0) begin n_fails++; $display("FAIL reset_matches: got %b expected 0", page_offset_matches_o); end
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_store(56'h1000 + 56'(8 * i));
      #1;
      n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL fill_ready_%0d: got %b expected 1", i, ready_o); end
      if (i == 0) begin
        n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL fill_commit_ready_before: got %b expected 0", commit_ready_o); end
      end
      if (i == 1) begin
        n_checks++; if (commit_ready_o !== 1'b1) begin n_fails++; $display("FAIL fill_commit_ready_after: got %b expected 1", commit_ready_o); end
      end
      step();
    end
    drive_store(56'h1020);
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_fails++; $display("FAIL fill_full_ready: got %b expected 0", ready_o); end
    step();
    n_checks++; if (ready_o !== 1'b0) begin n_fails++; $display("FAIL fill_fifth_ready: got %b expected 0", ready_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL fill_req: got %b expected 0", req_o); end
    valid_i = 1'b0;
  endtask

  task automatic test_commit_drain();
    commit_i = 1'b1;
    #1;
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL drain_req_before: got %b expected 0", req_o); end
    step();
    // Second commit this cycle; first commit must already be requesting.
    #1;
    n_checks++; if (req_o !== 1'b1) begin n_fails++; $display("FAIL drain_req_rise: got %b expected 1", req_o); end
    n_checks++; if (wdata_o !== data_of(56'h1000)) begin n_fails++; $display("FAIL drain_wdata: got %h expected %h", wdata_o, data_of(56'h1000)); end
    n_checks++; if (be_o !== be_of(56'h1000)) begin n_fails++; $display("FAIL drain_be: got %h expected %h", be_o, be_of(56'h1000)); end
    n_checks++; if (size_o !== size_of(56'h1000)) begin n_fails++; $display("FAIL drain_size: got %h expected %h", size_o, size_of(56'h1000)); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (addr_o !== 56'h1000) begin n_fails++; $display("FAIL drain_hold_%0d: got %h expected %h", c, addr_o, 56'h1000); end
      step();
      commit_i = 1'b0;
    end
    gnt_i = 1'b1;
    #1;
    step();
    gnt_i = 1'b0;
    #1;
    n_checks++; if (addr_o !== 56'h1008) begin n_fails++; $display("FAIL drain_next_addr: got %h expected %h", addr_o, 56'h1008); end
    n_checks++; if (wdata_o !== data_of(56'h1008)) begin n_fails++; $display("FAIL drain_next_wdata: got %h expected %h", wdata_o, data_of(56'h1008)); end
  endtask

  task automatic test_flush();
    // spec {1010,1018} commit {1008}; one more push makes 3 speculative.
    drive_store(56'h1020);
    step();
    drive_store(56'h3000);
    flush_i  = 1'b1;
    commit_i = 1'b1;
    step();
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    commit_i = 1'b0;
    #1;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL flush_spec_empty: commit_ready got %b expected 0", commit_ready_o); end
    n_checks++; if (empty_o !== 1'b0) begin n_fails++; $display("FAIL flush_empty: got %b expected 0", empty_o); end
    n_checks++; if (addr_o !== 56'h1008) begin n_fails++; $display("FAIL flush_head0: got %h expected %h", addr_o, 56'h1008); end
    gnt_i = 1'b1;
    step();
    n_checks++; if (addr_o !== 56'h1010) begin n_fails++; $display("FAIL flush_head1: got %h expected %h", addr_o, 56'h1010); end
    n_checks++; if (req_o !== 1'b1) begin n_fails++; $display("FAIL flush_req1: got %b expected 1", req_o); end
    step();
    gnt_i = 1'b0;
    #1;
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL flush_drained_req: got %b expected 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("FAIL flush_drained_empty: got %b expected 1", empty_o); end
    n_checks++; if (no_st_pending_o !== 1'b1) begin n_fails++; $display("FAIL flush_no_st_pending: got %b expected 1", no_st_pending_o); end
  endtask

  task automatic test_back_to_back();
    drive_store(56'h0F00);
    step();
    drive_store(56'h1000);
    commit_i = 1'b1;
    step();
    // spec {1000}, commit {0F00}: push, commit and grant together.
    drive_store(56'h2000);
    commit_i = 1'b1;
    gnt_i    = 1'b1;
    #1;
    n_checks++; if (addr_o !== 56'h0F00) begin n_fails++; $display("FAIL b2b_head_before: got %h expected %h", addr_o, 56'h0F00); end
    step();
    valid_i  = 1'b0;
    commit_i = 1'b0;
    gnt_i    = 1'b0;
    #1;
    n_checks++; if (addr_o !== 56'h1000) begin n_fails++; $display("FAIL b2b_head_after: got %h expected %h", addr_o, 56'h1000); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fails++; $display("FAIL b2b_commit_ready: got %b expected 1", commit_ready_o); end
    n_checks++; if (req_o !== 1'b1) begin n_fails++; $display("FAIL b2b_req: got %b expected 1", req_o); end
    commit_i = 1'b1;
    gnt_i    = 1'b1;
    step();
    commit_i = 1'b0;
    #1;
    n_checks++; if (addr_o !== 56'h2000) begin n_fails++; $display("FAIL b2b_last_head: got %h expected %h", addr_o, 56'h2000); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL b2b_spec_drained: commit_ready got %b expected 0", commit_ready_o); end
    step();
    gnt_i = 1'b0;
    #1;
    n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("FAIL b2b_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_commit_full();
    for (int i = 0; i < 4; i++) begin
      drive_store(56'h6000 + 56'(8 * i));
      step();
    end
    valid_i  = 1'b0;
    commit_i = 1'b1;
    repeat (4) step();
    commit_i = 1'b0;
    drive_store(56'h6020);
    step();
    valid_i = 1'b0;
    #1;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL full_commit_ready: got %b expected 0", commit_ready_o); end
    gnt_i = 1'b1;
    #1;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL full_no_bypass: got %b expected 0", commit_ready_o); end
    n_checks++; if (addr_o !== 56'h6000) begin n_fails++; $display("FAIL full_head: got %h expected %h", addr_o, 56'h6000); end
    step();
    gnt_i = 1'b0;
    #1;
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fails++; $display("FAIL full_slot_freed: got %b expected 1", commit_ready_o); end
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    gnt_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (addr_o !== 56'h6008 + 56'(8 * k)) begin n_fails++; $display("FAIL full_drain_%0d: got %h expected %h", k, addr_o, 56'h6008 + 56'(8 * k)); end
      step();
    end
    gnt_i = 1'b0;
    #1;
    n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("FAIL full_drained_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_page_check();
    logic exp_miss;
`ifdef ST_COMMIT_QUEUE_PAGE_CHECK_EN
    exp_miss = 1'b0;
`else
    exp_miss = 1'b1;
`endif
    drive_store(56'h5010);
    step();
    valid_i = 1'b0;
    page_offset_i = 12'h010;
    #1;
    n_checks++; if (page_offset_matches_o !== 1'b1) begin n_fails++; $display("FAIL page_spec_hit: got %b expected 1", page_offset_matches_o); end
    page_offset_i = 12'h018;
    #1;
    n_checks++; if (page_offset_matches_o !== exp_miss) begin n_fails++; $display("FAIL page_spec_miss: got %b expected %b", page_offset_matches_o, exp_miss); end
    drive_store(56'h7018);
    #1;
    n_checks++; if (page_offset_matches_o !== 1'b1) begin n_fails++; $display("FAIL page_incoming_hit: got %b expected 1", page_offset_matches_o); end
    valid_i  = 1'b0;
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    page_offset_i = 12'h010;
    #1;
    n_checks++; if (page_offset_matches_o !== 1'b1) begin n_fails++; $display("FAIL page_commit_hit: got %b expected 1", page_offset_matches_o); end
    page_offset_i = 12'h018;
    #1;
    n_checks++; if (page_offset_matches_o !== exp_miss) begin n_fails++; $display("FAIL page_commit_miss: got %b expected %b", page_offset_matches_o, exp_miss); end
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    page_offset_i = 12'h010;
    #1;
    n_checks++; if (page_offset_matches_o !== 1'b0) begin n_fails++; $display("FAIL page_empty: got %b expected 0", page_offset_matches_o); end
  endtask

  task automatic test_reset_mid_drain();
    drive_store(56'h8000);
    step();
    drive_store(56'h8008);
    step();
    valid_i  = 1'b0;
    commit_i = 1'b1;
    repeat (2) step();
    commit_i = 1'b0;
    #1;
    n_checks++; if (req_o !== 1'b1) begin n_fails++; $display("FAIL rstmid_req_before: got %b expected 1", req_o); end
    rst_i = 1'b1;
    #1;
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL rstmid_req: got %b expected 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("FAIL rstmid_empty: got %b expected 1", empty_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL rstmid_ready: got %b expected 1", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fails++; $display("FAIL rstmid_commit_ready: got %b expected 0", commit_ready_o); end
    step();
    step();
    rst_i = 1'b0;
    #1;
    n_checks++; if (req_o !== 1'b0) begin n_fails++; $display("FAIL rstmid_after_release: got %b expected 0", req_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_commit_drain();
    test_flush();
    test_back_to_back();
    test_commit_full();
    test_page_check();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
